// File: rtl/shadow_scan.sv
// Any-hit scan sequencer: streams a contiguous triangle range into the intersection stage
// and returns one hit/miss response. Define SHADOW_EARLY_EXIT_EN to stop at the first valid hit.
module shadow_scan #(
    parameter int ADDR_W = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [0:1][0:2][31:0]     i_req_ray,
    input  logic [ADDR_W-1:0]         i_req_first,
    input  logic [ADDR_W-1:0]         i_req_count,
    output logic                      o_tri_rd,
    output logic [ADDR_W-1:0]         o_tri_addr,
    input  logic [0:2][0:2][31:0]     i_tri_data,
    output logic [0:1][0:2][31:0]     o_ray,
    output logic [0:2][0:2][31:0]     o_triangle,
    input  logic                      i_isect_result,
    input  logic                      i_isect_invalid,
    input  logic [0:2][31:0]          i_isect_normal,
    output logic                      o_resp_valid,
    input  logic                      i_resp_ready,
    output logic                      o_hit,
    output logic [ADDR_W-1:0]         o_hit_idx,
    output logic [0:2][31:0]          o_hit_normal,
    output logic [7:0]                o_invalid_cnt
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESP} state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_W-1:0]      addr_reg;
    logic [ADDR_W-1:0]      remain_reg;
    logic                   s1_valid_reg, s2_valid_reg;
    logic [ADDR_W-1:0]      s1_idx_reg, s2_idx_reg;
    logic [0:1][0:2][31:0]  ray_reg;
    logic [0:2][0:2][31:0]  triangle_reg;
    logic                   hit_reg;
    logic [ADDR_W-1:0]      hit_idx_reg;
    logic [7:0]             invalid_cnt_reg;
    logic [31:0]            normal_reg [3];

    logic accept;
    logic eval;
    logic eval_hit;
    logic exit_now;

    assign accept   = i_req_valid && (state_reg == IDLE);
    // s2 holds the triangle currently presented to the intersection stage
    assign eval     = s2_valid_reg && ((state_reg == SCAN) || (state_reg == DRAIN));
    assign eval_hit = eval && i_isect_result && !i_isect_invalid;

`ifdef SHADOW_EARLY_EXIT_EN
    assign exit_now = eval_hit;
`else
    assign exit_now = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (i_req_count == '0) ? RESP : SCAN;
                end
            end
            SCAN: begin
                if (exit_now) begin
                    state_next = RESP;
                end else if (remain_reg == ADDR_W'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Last triangle is being evaluated once nothing is left in s1
                if (exit_now || !s1_valid_reg) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            remain_reg      <= '0;
            s1_valid_reg    <= 1'b0;
            s2_valid_reg    <= 1'b0;
            s1_idx_reg      <= '0;
            s2_idx_reg      <= '0;
            ray_reg         <= '0;
            triangle_reg    <= '0;
            hit_reg         <= 1'b0;
            hit_idx_reg     <= '0;
            invalid_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            s1_valid_reg <= o_tri_rd;
            s1_idx_reg   <= addr_reg;
            s2_valid_reg <= s1_valid_reg && !exit_now;
            s2_idx_reg   <= s1_idx_reg;

            if (s1_valid_reg) begin
                triangle_reg <= i_tri_data;
            end

            if (accept) begin
                ray_reg    <= i_req_ray;
                addr_reg   <= i_req_first;
                remain_reg <= i_req_count;
            end else if (o_tri_rd) begin
                addr_reg   <= addr_reg + ADDR_W'(1);
                remain_reg <= remain_reg - ADDR_W'(1);
            end

            if (accept) begin
                hit_reg         <= 1'b0;
                hit_idx_reg     <= '0;
                invalid_cnt_reg <= '0;
            end else if (eval) begin
                if (i_isect_invalid) begin
                    if (invalid_cnt_reg != 8'hFF) begin
                        invalid_cnt_reg <= invalid_cnt_reg + 8'd1;
                    end
                end else if (i_isect_result && !hit_reg) begin
                    hit_reg     <= 1'b1;
                    hit_idx_reg <= s2_idx_reg;
                end
            end
        end
    end

    // Normal is latched only for the first (lowest-index) valid hit
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_normal
            always_ff @(posedge i_clk) begin
                if (i_rst || accept) begin
                    normal_reg[gi] <= '0;
                end else if (eval_hit && !hit_reg) begin
                    normal_reg[gi] <= i_isect_normal[gi];
                end
            end
            assign o_hit_normal[gi] = normal_reg[gi];
        end
    endgenerate

    assign o_req_ready   = (state_reg == IDLE);
    assign o_resp_valid  = (state_reg == RESP);
    assign o_tri_rd      = (state_reg == SCAN) && !exit_now;
    assign o_tri_addr    = addr_reg;
    assign o_ray         = ray_reg;
    assign o_triangle    = triangle_reg;
    assign o_hit         = hit_reg;
    assign o_hit_idx     = hit_idx_reg;
    assign o_invalid_cnt = invalid_cnt_reg;

endmodule

// File: tb/tb_shadow_scan.sv
// Bench for shadow_scan: memory and intersection models driven from per-test hit/invalid maps,
// table of requests with expected responses, plus reset-abort and backpressure sequences.
module tb_shadow_scan;

    typedef logic [319:0] w_t;

    typedef struct {
        logic [15:0] first;
        int          count;
        logic [15:0] hit_mask;
        logic [15:0] inv_mask;
        bit          inv_all;
        bit          exp_hit;
        logic [15:0] exp_idx;
        int          exp_inv;
        int          exp_lat;
        int          ee_inv;
        int          ee_lat;
    } vec_t;

    typedef struct {
        bit              hit;
        logic [15:0]     idx;
        logic [0:2][31:0] normal;
        logic [7:0]      inv;
        int              lat;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  i_rst;
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic [0:1][0:2][31:0] i_req_ray;
    logic [15:0]           i_req_first;
    logic [15:0]           i_req_count;
    logic                  o_tri_rd;
    logic [15:0]           o_tri_addr;
    logic [0:2][0:2][31:0] tri_data;
    logic [0:1][0:2][31:0] o_ray;
    logic [0:2][0:2][31:0] o_triangle;
    logic                  isect_result;
    logic                  isect_invalid;
    logic [0:2][31:0]      isect_normal;
    logic                  o_resp_valid;
    logic                  i_resp_ready;
    logic                  o_hit;
    logic [15:0]           o_hit_idx;
    logic [0:2][31:0]      o_hit_normal;
    logic [7:0]            o_invalid_cnt;

    int   checks = 0;
    int   errors = 0;
    bit   hit_map [0:65535];
    bit   inv_map [0:65535];
    exp_t exp_q [$];
    vec_t vecs [10];

    shadow_scan #(.ADDR_W(16)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_ray      (i_req_ray),
        .i_req_first    (i_req_first),
        .i_req_count    (i_req_count),
        .o_tri_rd       (o_tri_rd),
        .o_tri_addr     (o_tri_addr),
        .i_tri_data     (tri_data),
        .o_ray          (o_ray),
        .o_triangle     (o_triangle),
        .i_isect_result (isect_result),
        .i_isect_invalid(isect_invalid),
        .i_isect_normal (isect_normal),
        .o_resp_valid   (o_resp_valid),
        .i_resp_ready   (i_resp_ready),
        .o_hit          (o_hit),
        .o_hit_idx      (o_hit_idx),
        .o_hit_normal   (o_hit_normal),
        .o_invalid_cnt  (o_invalid_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [0:2][0:2][31:0] make_tri(input logic [15:0] a);
        logic [0:2][0:2][31:0] t;
        t = '0;
        t[0][0] = {16'hA5A5, a};
        t[1][1] = {~a, a};
        t[2][2] = {16'h0000, ~a};
        return t;
    endfunction

    // Triangle memory: one-cycle read latency
    always @(posedge clk) begin
        if (o_tri_rd) tri_data <= make_tri(o_tri_addr);
    end

    // Intersection model keyed by the index embedded in the triangle; a corrupted
    // triangle never hits. Invalid triangles also raise result to test the gating.
    always_comb begin
        logic [15:0] idx;
        logic        tag_ok;
        idx           = o_triangle[0][0][15:0];
        tag_ok        = (o_triangle[0][0][31:16] == 16'hA5A5) &&
                        (o_triangle[1][1] == {~idx, idx}) &&
                        (o_triangle[2][2] == {16'h0000, ~idx});
        isect_result  = tag_ok && (hit_map[idx] || inv_map[idx]);
        isect_invalid = tag_ok && inv_map[idx];
        isect_normal  = {32'h00010000, 32'h00000000, {16'h0000, idx}};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rst        = 1'b0;
        i_req_valid  = 1'b0;
        i_resp_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"}, w_t'({o_req_ready, o_tri_rd, o_resp_valid, o_hit}), w_t'(4'b1000));
        check({tag, "_addr"}, w_t'(o_tri_addr), w_t'(16'h0000));
        check({tag, "_ray"}, w_t'(o_ray), w_t'(0));
        check({tag, "_triangle"}, w_t'(o_triangle), w_t'(0));
        check({tag, "_resp"}, w_t'({o_hit_idx, o_hit_normal, o_invalid_cnt}), w_t'(0));
    endtask

    task automatic set_maps(input vec_t v, input bit val);
        logic [15:0] a;
        for (int k = 0; k < v.count; k++) begin
            a = v.first + 16'(k);
            hit_map[a] = 1'b0;
            inv_map[a] = 1'b0;
            if (val) begin
                if (k < 16) begin
                    hit_map[a] = v.hit_mask[k[3:0]];
                    inv_map[a] = v.inv_mask[k[3:0]];
                end
                if (v.inv_all) inv_map[a] = 1'b1;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        logic [0:1][0:2][31:0] ray;
        exp_t e, got_e;
        int   reads, lat, exp_reads;
        bit   ray_bad, seen;
`ifdef SHADOW_EARLY_EXIT_EN
        logic [15:0] kd;
        int          k_hit;
`endif
        set_maps(v, 1'b1);
        e.hit    = v.exp_hit;
        e.idx    = v.exp_idx;
        e.normal = v.exp_hit ? {32'h00010000, 32'h00000000, {16'h0000, v.exp_idx}} : '0;
`ifdef SHADOW_EARLY_EXIT_EN
        e.inv     = 8'(v.ee_inv);
        e.lat     = v.ee_lat;
        kd        = v.exp_idx - v.first;
        k_hit     = int'(kd);
        exp_reads = (v.exp_hit && (k_hit + 2 < v.count)) ? k_hit + 2 : v.count;
`else
        e.inv     = 8'(v.exp_inv);
        e.lat     = v.exp_lat;
        exp_reads = v.count;
`endif
        exp_q.push_back(e);

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                ray[i][j] = $urandom();

        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_first = v.first;
        i_req_count = 16'(v.count);
        i_req_ray   = ray;
        check("req_ready_idle", w_t'(o_req_ready), w_t'(1'b1));
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;

        reads = 0; lat = 0; seen = 1'b0; ray_bad = 1'b0;
        for (int t = 1; t <= v.count + 20; t++) begin
            if (o_tri_rd) begin
                check("rd_slot_addr", w_t'({t, o_tri_addr}), w_t'({reads + 1, v.first + 16'(reads)}));
                reads++;
            end
            if (o_ray !== ray) ray_bad = 1'b1;
            if (o_resp_valid) begin
                lat  = t;
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end

        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: first=%h count=%0d got no response expected latency %0d",
                     v.first, v.count, e.lat);
            void'(exp_q.pop_front());
            set_maps(v, 1'b0);
            pulse_reset();
            return;
        end

        check("resp_latency", w_t'(lat), w_t'(e.lat));
        check("read_count", w_t'(reads), w_t'(exp_reads));
        check("ray_const", w_t'(ray_bad), w_t'(1'b0));

        for (int h = 0; h < hold; h++) begin
            check("hold_fields",
                  w_t'({o_resp_valid, o_tri_rd, o_hit, o_hit_idx, o_hit_normal, o_invalid_cnt}),
                  w_t'({1'b1, 1'b0, e.hit, e.idx, e.normal, e.inv}));
            @(negedge clk);
        end

        i_resp_ready = 1'b1;
        got_e = exp_q.pop_front();
        check("resp_hit", w_t'(o_hit), w_t'(got_e.hit));
        check("resp_idx", w_t'(o_hit_idx), w_t'(got_e.idx));
        check("resp_normal", w_t'(o_hit_normal), w_t'(got_e.normal));
        check("resp_inv_cnt", w_t'(o_invalid_cnt), w_t'(got_e.inv));
        $display("txn first=%h count=%0d hit=%0d idx=%h inv=%0d lat=%0d reads=%0d",
                 v.first, v.count, o_hit, o_hit_idx, o_invalid_cnt, lat, reads);
        @(posedge clk);
        @(negedge clk);
        i_resp_ready = 1'b0;
        check("ready_after_hs", w_t'({o_req_ready, o_resp_valid}), w_t'(2'b10));
        set_maps(v, 1'b0);
    endtask

    task automatic reset_abort();
        bit bad;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_first = 16'h0500;
        i_req_count = 16'd8;
        i_req_ray   = {6{32'hDEADBEEF}};
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_scanning", w_t'(o_tri_rd), w_t'(1'b1));
        i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        check_reset_state("abort");
        bad = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (o_resp_valid || o_tri_rd || !o_req_ready) bad = 1'b1;
            @(negedge clk);
        end
        check("abort_quiet", w_t'(bad), w_t'(1'b0));
        $display("txn reset abort first=0500 count=8 quiet=%0d", !bad);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_req_valid  = 1'b0;
        i_req_ray    = '0;
        i_req_first  = '0;
        i_req_count  = '0;
        i_resp_ready = 1'b0;
        tri_data     = '0;
        for (int a = 0; a < 65536; a++) begin
            hit_map[a] = 1'b0;
            inv_map[a] = 1'b0;
        end

        //           first     cnt  hit_mask  inv_mask  all  hit   idx       inv  lat  ee_inv ee_lat
        vecs[0] = '{16'h0010,    0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000,   0,   1,   0,   1};
        vecs[1] = '{16'h0020,    4, 16'h0004, 16'h0000, 1'b0, 1'b1, 16'h0022,   0,   7,   0,   6};
        vecs[2] = '{16'h0000,    3, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000,   0,   6,   0,   6};
        vecs[3] = '{16'hFFFE,    4, 16'h0008, 16'h0002, 1'b0, 1'b1, 16'h0001,   1,   7,   1,   7};
        vecs[4] = '{16'h0100,    5, 16'h0012, 16'h0008, 1'b0, 1'b1, 16'h0101,   1,   8,   0,   5};
        vecs[5] = '{16'h0200,    1, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0200,   0,   4,   0,   4};
        vecs[6] = '{16'h0300,    6, 16'h0000, 16'h003F, 1'b0, 1'b0, 16'h0000,   6,   9,   6,   9};
        vecs[7] = '{16'h0400,    8, 16'h0001, 16'h00FE, 1'b0, 1'b1, 16'h0400,   7,  11,   0,   4};
        vecs[8] = '{16'h1000,  300, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 255, 303, 255, 303};
        vecs[9] = '{16'hFFFF,    2, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'hFFFF,   0,   5,   0,   4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        i_rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], (i == 1) ? 5 : i % 3);
        end

        reset_abort();
        run_vec(vecs[2], 0);
        run_vec(vecs[4], 2);

        check("scoreboard_empty", w_t'(exp_q.size()), w_t'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
